time_counter: RTL

Timekeeping stage directly downstream of the 1 Hz divider. Consumes the divider's active-low 1 Hz square wave, detects the start of each period, and maintains a 24-hour BCD time of day (hours, minutes, seconds) with a synchronous load port. Its outputs feed the display and alarm logic.

---
 rtl/time_counter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/time_counter.sv
// time_counter: 24-hour BCD time of day driven by the active-low 1 Hz square
// wave from the divider. Detects the rising edge of that wave (the start of
// each period) and advances seconds/minutes/hours with a single-cycle ripple.
// A synchronous load port replaces the time, with range checking on the inputs.
module time_counter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       sig_1hz_ni,
    input  logic       set_i,
    input  logic [7:0] set_hour_i,
    input  logic [7:0] set_min_i,
    input  logic [7:0] set_sec_i,
    output logic [7:0] hour_o,
    output logic [7:0] min_o,
    output logic [7:0] sec_o,
    output logic       sec_tick_o,
    output logic       min_tick_o,
    output logic       day_tick_o,
    output logic       set_err_o
);

    // Field order used by the load validator: 0 = seconds, 1 = minutes, 2 = hours.
    localparam logic [7:0] MAX_VAL [3] = '{8'h59, 8'h59, 8'h23};

    // Increment a two-digit BCD value, wrapping to 00 once it has reached max_v.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == max_v) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    logic       sig_q_reg;
    logic [7:0] sec_reg,  sec_next;
    logic [7:0] min_reg,  min_next;
    logic [7:0] hour_reg, hour_next;
    logic       sec_tick_reg, sec_tick_next;
    logic       min_tick_reg, min_tick_next;
    logic       day_tick_reg, day_tick_next;
    logic       set_err_reg,  set_err_next;

    logic       period_start;
    logic       tick;
    logic [7:0] set_val [3];
    logic [2:0] field_ok;
    logic       set_ok;
    logic       sec_wrap;
    logic       min_wrap;
    logic       day_wrap;

    // Rising edge of the active-low wave marks the divider's counter==0 point.
    // Edges seen while disabled are simply dropped.
    assign period_start = ~sig_q_reg & sig_1hz_ni;
    assign tick         = period_start & enable_i;

    assign set_val[0] = set_sec_i;
    assign set_val[1] = set_min_i;
    assign set_val[2] = set_hour_i;

    // With the units digit known to be <= 9, a plain binary compare against
    // the BCD maximum also bounds the tens digit correctly.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_field_check
            assign field_ok[gi] = (set_val[gi][3:0] <= 4'd9) && (set_val[gi] <= MAX_VAL[gi]);
        end
    endgenerate

    assign set_ok = &field_ok;

    assign sec_wrap = (sec_reg == 8'h59);
    assign min_wrap = sec_wrap && (min_reg == 8'h59);
    assign day_wrap = min_wrap && (hour_reg == 8'h23);

    // Next-state: load beats tick; a tick coinciding with a load is discarded.
    always_comb begin
        sec_next      = sec_reg;
        min_next      = min_reg;
        hour_next     = hour_reg;
        sec_tick_next = 1'b0;
        min_tick_next = 1'b0;
        day_tick_next = 1'b0;
        set_err_next  = 1'b0;
        if (set_i) begin
            if (set_ok) begin
                sec_next  = set_sec_i;
                min_next  = set_min_i;
                hour_next = set_hour_i;
            end else begin
                set_err_next = 1'b1;
            end
        end else if (tick) begin
            sec_next      = bcd_inc(sec_reg, 8'h59);
            sec_tick_next = 1'b1;
            if (sec_wrap) begin
                min_next      = bcd_inc(min_reg, 8'h59);
                min_tick_next = 1'b1;
            end
            if (min_wrap) begin
                hour_next = bcd_inc(hour_reg, 8'h23);
            end
            day_tick_next = day_wrap;
        end
    end

    // Edge-detector history; resets to the divider's idle (high) level so
    // that no tick is generated by reset itself.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q_reg <= 1'b1;
        end else begin
            sig_q_reg <= sig_1hz_ni;
        end
    end

    // Time-of-day counters and one-cycle status pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sec_reg      <= 8'h00;
            min_reg      <= 8'h00;
            hour_reg     <= 8'h00;
            sec_tick_reg <= 1'b0;
            min_tick_reg <= 1'b0;
            day_tick_reg <= 1'b0;
            set_err_reg  <= 1'b0;
        end else begin
            sec_reg      <= sec_next;
            min_reg      <= min_next;
            hour_reg     <= hour_next;
            sec_tick_reg <= sec_tick_next;
            min_tick_reg <= min_tick_next;
            day_tick_reg <= day_tick_next;
            set_err_reg  <= set_err_next;
        end
    end

    assign sec_o      = sec_reg;
    assign min_o      = min_reg;
    assign hour_o     = hour_reg;
    assign sec_tick_o = sec_tick_reg;
    assign min_tick_o = min_tick_reg;
    assign day_tick_o = day_tick_reg;
    assign set_err_o  = set_err_reg;

endmodule
